// File: rtl/apb_cfg_slave_if.sv
// APB3 bus bundle between a bus master and apb_cfg_slave.
//   master modport : drives psel/penable/pwrite/paddr/pwdata, sees pready/prdata/pslverr
//   slave  modport : the mirror image
interface apb_cfg_slave_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_cfg_slave.sv
// APB3 register slave in front of an 8-bit config register.
// Bus writes to CONFIG become a one-cycle cfg_wr_en_o/cfg_wr_data_o strobe;
// reads of CONFIG return cfg_rd_data_i. Also holds a write counter (STATUS),
// a scratch byte and flags bad accesses with pslverr.
// Ports:
//   clk, rst        clock (posedge) and asynchronous active-high reset
//   apb             APB slave modport (psel/penable/pwrite/paddr/pwdata in,
//                   pready/prdata/pslverr out, all outputs registered)
//   cfg_wr_en_o     one-cycle write strobe to the config register
//   cfg_wr_data_o   value to write into the config register
//   cfg_rd_data_i   current config register contents
// Register map: 0x0 CONFIG (RW), 0x4 STATUS (RO, wr_count), 0x8 SCRATCH (RW).
// Optional: define CFG_LOCK_EN to add 0xC LOCK (bit0, set-once until reset),
// which blocks further CONFIG writes with pslverr.
// WAIT_STATES must lie in 0..15.
module apb_cfg_slave #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  apb_cfg_slave_if.slave      apb,
  output logic                cfg_wr_en_o,
  output logic [7:0]          cfg_wr_data_o,
  input  logic [7:0]          cfg_rd_data_i
);

  localparam int unsigned CNT_W = 4;

  localparam logic [ADDR_W-1:0] ADDR_CONFIG  = ADDR_W'(4'h0);
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = ADDR_W'(4'h4);
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH = ADDR_W'(4'h8);
`ifdef CFG_LOCK_EN
  localparam logic [ADDR_W-1:0] ADDR_LOCK    = ADDR_W'(4'hC);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                pready_q, pready_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                pslverr_q, pslverr_d;
  logic                wr_en_q, wr_en_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [7:0]          wr_count_q, wr_count_d;
  logic [7:0]          scratch_q, scratch_d;
`ifdef CFG_LOCK_EN
  logic                lock_q, lock_d;
`endif

  logic                locked_c;
  logic                access_err_c;
  logic [7:0]          rd_byte_c;
  logic                unused_pwdata_hi;

  // Only the low byte of pwdata is stored; the rest is intentionally dropped.
  assign unused_pwdata_hi = ^(apb.pwdata >> 8);

`ifdef CFG_LOCK_EN
  assign locked_c = lock_q;
`else
  assign locked_c = 1'b0;
`endif

  // Address decode of the captured transfer: error flag and read byte.
  always_comb begin
    access_err_c = 1'b1;
    rd_byte_c    = 8'h00;
    if (addr_q == ADDR_CONFIG) begin
      access_err_c = write_q && locked_c;
      rd_byte_c    = cfg_rd_data_i;
    end else if (addr_q == ADDR_STATUS) begin
      access_err_c = write_q;
      rd_byte_c    = wr_count_q;
    end else if (addr_q == ADDR_SCRATCH) begin
      access_err_c = 1'b0;
      rd_byte_c    = scratch_q;
    end
`ifdef CFG_LOCK_EN
    else if (addr_q == ADDR_LOCK) begin
      access_err_c = 1'b0;
      rd_byte_c    = {7'b0, lock_q};
    end
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    pready_d   = 1'b0;
    prdata_d   = '0;
    pslverr_d  = 1'b0;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    wr_count_d = wr_count_q;
    scratch_d  = scratch_q;
`ifdef CFG_LOCK_EN
    lock_d     = lock_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d = ST_SETUP;
          addr_d  = apb.paddr;
          write_d = apb.pwrite;
          wdata_d = apb.pwdata[7:0];
        end
      end
      ST_SETUP: begin
        if (apb.psel && apb.penable) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(WAIT_STATES);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!(apb.psel && apb.penable)) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          // Response is registered on entry so it lines up with the DONE cycle.
          state_d   = ST_DONE;
          pready_d  = 1'b1;
          pslverr_d = access_err_c;
          if (!write_q && !access_err_c) begin
            prdata_d = DATA_W'(rd_byte_c);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        // Side effects commit here so an aborted transfer never reaches them.
        if (write_q && !access_err_c) begin
          if (addr_q == ADDR_CONFIG) begin
            wr_en_d    = 1'b1;
            wr_data_d  = wdata_q;
            wr_count_d = wr_count_q + 8'd1;
          end
          if (addr_q == ADDR_SCRATCH) begin
            scratch_d = wdata_q;
          end
`ifdef CFG_LOCK_EN
          if (addr_q == ADDR_LOCK && wdata_q[0]) begin
            lock_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= 8'h00;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 8'h00;
      wr_count_q <= 8'h00;
      scratch_q  <= 8'h00;
`ifdef CFG_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      pready_q   <= pready_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
      scratch_q  <= scratch_d;
`ifdef CFG_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign apb.pready    = pready_q;
  assign apb.prdata    = prdata_q;
  assign apb.pslverr   = pslverr_q;
  assign cfg_wr_en_o   = wr_en_q;
  assign cfg_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_apb_cfg_slave.sv
// Testbench for apb_cfg_slave: two instances (WAIT_STATES=0 and 3) with a
// queue-based scoreboard for APB responses and config write strobes.
module tb_apb_cfg_slave;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] rd;
    logic              err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]              m_psel, m_penable, m_pwrite;
  logic [1:0][ADDR_W-1:0]  m_paddr;
  logic [1:0][DATA_W-1:0]  m_pwdata;
  logic [1:0]              s_pready, s_pslverr;
  logic [1:0][DATA_W-1:0]  s_prdata;
  logic [1:0]              wr_en;
  logic [1:0][7:0]         wr_data;
  logic [1:0][7:0]         cfg_reg;

  int vectors = 0;
  int fails   = 0;

  exp_t       exp_q [2][$];
  logic [7:0] stb_q [2][$];

  apb_cfg_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
  apb_cfg_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  assign bus0.psel    = m_psel[0];
  assign bus0.penable = m_penable[0];
  assign bus0.pwrite  = m_pwrite[0];
  assign bus0.paddr   = m_paddr[0];
  assign bus0.pwdata  = m_pwdata[0];
  assign bus1.psel    = m_psel[1];
  assign bus1.penable = m_penable[1];
  assign bus1.pwrite  = m_pwrite[1];
  assign bus1.paddr   = m_paddr[1];
  assign bus1.pwdata  = m_pwdata[1];

  assign s_pready[0]  = bus0.pready;
  assign s_prdata[0]  = bus0.prdata;
  assign s_pslverr[0] = bus0.pslverr;
  assign s_pready[1]  = bus1.pready;
  assign s_prdata[1]  = bus1.prdata;
  assign s_pslverr[1] = bus1.pslverr;

  apb_cfg_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(0)) u_dut0 (
    .clk           (clk),
    .rst           (rst),
    .apb           (bus0),
    .cfg_wr_en_o   (wr_en[0]),
    .cfg_wr_data_o (wr_data[0]),
    .cfg_rd_data_i (cfg_reg[0])
  );

  apb_cfg_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(3)) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .apb           (bus1),
    .cfg_wr_en_o   (wr_en[1]),
    .cfg_wr_data_o (wr_data[1]),
    .cfg_rd_data_i (cfg_reg[1])
  );

  // Downstream 8-bit config registers fed by the strobes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_reg <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (wr_en[i]) cfg_reg[i] <= wr_data[i];
    end
  end

  // Monitor: pops expected responses/strobes whenever the DUT presents one.
  logic [1:0] prev_pready = '0;
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] sd;
    for (int i = 0; i < 2; i++) begin
      if (s_pready[i]) begin
        vectors++;
        if (exp_q[i].size() == 0) begin
          fails++;
          $display("FAIL pready_unexpected dut%0d: got pready=1 prdata=%h pslverr=%b, required no response",
                   i, s_prdata[i], s_pslverr[i]);
        end else begin
          e = exp_q[i].pop_front();
          if (s_prdata[i] !== e.rd || s_pslverr[i] !== e.err) begin
            fails++;
            $display("FAIL response dut%0d: got prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                     i, s_prdata[i], s_pslverr[i], e.rd, e.err);
          end
        end
      end else if (s_prdata[i] !== '0 || s_pslverr[i] !== 1'b0) begin
        vectors++;
        fails++;
        $display("FAIL idle_response dut%0d: got prdata=%h pslverr=%b without pready, required 0/0",
                 i, s_prdata[i], s_pslverr[i]);
      end
      if (wr_en[i]) begin
        vectors++;
        if (stb_q[i].size() == 0) begin
          fails++;
          $display("FAIL strobe_unexpected dut%0d: got cfg_wr_en=1 data=%h, required no strobe", i, wr_data[i]);
        end else begin
          sd = stb_q[i].pop_front();
          if (wr_data[i] !== sd || !prev_pready[i]) begin
            fails++;
            $display("FAIL strobe dut%0d: got data=%h after_done=%b, required data=%h after_done=1",
                     i, wr_data[i], prev_pready[i], sd);
          end
        end
      end
    end
    prev_pready <= s_pready;
  end

  task automatic check_outputs_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (s_pready[i] !== 1'b0 || s_prdata[i] !== '0 || s_pslverr[i] !== 1'b0 ||
          wr_en[i] !== 1'b0 || wr_data[i] !== 8'h00) begin
        fails++;
        $display("FAIL %s dut%0d: got pready=%b prdata=%h pslverr=%b wr_en=%b wr_data=%h, required all 0",
                 name, i, s_pready[i], s_prdata[i], s_pslverr[i], wr_en[i], wr_data[i]);
      end
    end
  endtask

  task automatic clear_bus(input int d);
    m_psel[d]    = 1'b0;
    m_penable[d] = 1'b0;
    m_pwrite[d]  = 1'b0;
    m_paddr[d]   = '0;
    m_pwdata[d]  = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset_pulse");
    rst = 1'b0;
  endtask

  // abort: 0 = complete, 1 = drop psel/penable in WAIT, 2 = assert rst in WAIT.
  task automatic apb_xfer(input int d, input bit wr, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input bit exp_err, input int abort, input string name);
    int lat;
    bit seen;
    int exp_lat;
    exp_lat = (d == 0) ? 2 : 5;
    @(negedge clk);
    m_psel[d]    = 1'b1;
    m_penable[d] = 1'b0;
    m_pwrite[d]  = wr;
    m_paddr[d]   = addr;
    m_pwdata[d]  = wdata;
    if (abort == 0) begin
      exp_q[d].push_back('{rd: exp_rd, err: exp_err});
      if (wr && addr == 8'h00 && !exp_err) stb_q[d].push_back(wdata[7:0]);
    end
    @(negedge clk);
    m_penable[d] = 1'b1;
    if (abort != 0) begin
      @(negedge clk);
      if (abort == 1) begin
        clear_bus(d);
      end else begin
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero(name);
        clear_bus(d);
        rst = 1'b0;
      end
      repeat (6) @(negedge clk);
      return;
    end
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      seen = s_pready[d];
    end
    vectors++;
    if (!seen || lat != exp_lat) begin
      fails++;
      $display("FAIL latency %s dut%0d: got %0d cycles (seen=%b), required %0d", name, d, lat, seen, exp_lat);
    end
    clear_bus(d);
  endtask

  initial begin
    rst = 1'b1;
    clear_bus(0);
    clear_bus(1);
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_state");
    rst = 1'b0;

    // Config write with upper data bits set, then STATUS.
    apb_xfer(0, 1'b1, 8'h00, 32'hFFFF_FF05, 32'h0, 1'b0, 0, "wr_config");
    apb_xfer(0, 1'b0, 8'h04, 32'h0, 32'h0000_0001, 1'b0, 0, "rd_status");
    apb_xfer(0, 1'b0, 8'h00, 32'h0, 32'h0000_0005, 1'b0, 0, "rd_config");

    // Three wait states: CONFIG and SCRATCH round trips.
    apb_xfer(1, 1'b1, 8'h00, 32'h0000_00A6, 32'h0, 1'b0, 0, "ws3_wr_config");
    apb_xfer(1, 1'b0, 8'h00, 32'h0, 32'h0000_00A6, 1'b0, 0, "ws3_rd_config");
    apb_xfer(1, 1'b1, 8'h08, 32'h1234_563C, 32'h0, 1'b0, 0, "ws3_wr_scratch");
    apb_xfer(1, 1'b0, 8'h08, 32'h0, 32'h0000_003C, 1'b0, 0, "ws3_rd_scratch");

    // Bad accesses.
    apb_xfer(0, 1'b0, 8'h10, 32'h0, 32'h0, 1'b1, 0, "rd_0x10");
    apb_xfer(0, 1'b1, 8'h10, 32'h0000_0099, 32'h0, 1'b1, 0, "wr_0x10");
    apb_xfer(0, 1'b1, 8'h04, 32'h0000_0055, 32'h0, 1'b1, 0, "wr_status");
    apb_xfer(0, 1'b0, 8'h84, 32'h0, 32'h0, 1'b1, 0, "rd_upper_addr");
    apb_xfer(0, 1'b0, 8'h02, 32'h0, 32'h0, 1'b1, 0, "rd_unaligned");
`ifndef CFG_LOCK_EN
    apb_xfer(0, 1'b0, 8'h0C, 32'h0, 32'h0, 1'b1, 0, "rd_0x0c");
    apb_xfer(0, 1'b1, 8'h0C, 32'h0000_0001, 32'h0, 1'b1, 0, "wr_0x0c");
`endif
    apb_xfer(0, 1'b0, 8'h04, 32'h0, 32'h0000_0001, 1'b0, 0, "rd_status_unchanged");

    // Abort by dropping penable during WAIT.
    apb_xfer(1, 1'b1, 8'h00, 32'h0000_0011, 32'h0, 1'b0, 1, "abort_penable");
    apb_xfer(1, 1'b0, 8'h04, 32'h0, 32'h0000_0001, 1'b0, 0, "rd_status_after_abort");
    apb_xfer(1, 1'b0, 8'h00, 32'h0, 32'h0000_00A6, 1'b0, 0, "rd_config_after_abort");

    // Reset mid-WAIT.
    apb_xfer(1, 1'b1, 8'h00, 32'h0000_0022, 32'h0, 1'b0, 2, "reset_mid_wait");
    apb_xfer(1, 1'b0, 8'h04, 32'h0, 32'h0, 1'b0, 0, "rd_status_after_rst");
    apb_xfer(1, 1'b0, 8'h08, 32'h0, 32'h0, 1'b0, 0, "rd_scratch_after_rst");
    apb_xfer(0, 1'b0, 8'h04, 32'h0, 32'h0, 1'b0, 0, "rd_status0_after_rst");

    // 256 config writes wrap the counter.
    for (int i = 0; i < 256; i++)
      apb_xfer(0, 1'b1, 8'h00, 32'(i), 32'h0, 1'b0, 0, "wrap_wr");
    apb_xfer(0, 1'b0, 8'h04, 32'h0, 32'h0000_0000, 1'b0, 0, "rd_status_wrapped");
    apb_xfer(0, 1'b0, 8'h00, 32'h0, 32'h0000_00FF, 1'b0, 0, "rd_config_last");

`ifdef CFG_LOCK_EN
    apb_xfer(0, 1'b1, 8'h0C, 32'h0000_0000, 32'h0, 1'b0, 0, "wr_lock_0");
    apb_xfer(0, 1'b0, 8'h0C, 32'h0, 32'h0000_0000, 1'b0, 0, "rd_lock_clear");
    apb_xfer(0, 1'b1, 8'h0C, 32'h0000_0001, 32'h0, 1'b0, 0, "wr_lock_1");
    apb_xfer(0, 1'b1, 8'h00, 32'h0000_0007, 32'h0, 1'b1, 0, "wr_config_locked");
    apb_xfer(0, 1'b0, 8'h0C, 32'h0, 32'h0000_0001, 1'b0, 0, "rd_lock_set");
    apb_xfer(0, 1'b0, 8'h04, 32'h0, 32'h0000_0000, 1'b0, 0, "rd_status_locked");
    apb_xfer(0, 1'b1, 8'h0C, 32'h0000_0000, 32'h0, 1'b0, 0, "wr_lock_0_ignored");
    apb_xfer(0, 1'b0, 8'h0C, 32'h0, 32'h0000_0001, 1'b0, 0, "rd_lock_still_set");
    pulse_reset();
    apb_xfer(0, 1'b1, 8'h00, 32'h0000_0007, 32'h0, 1'b0, 0, "wr_config_unlocked");
    apb_xfer(0, 1'b0, 8'h0C, 32'h0, 32'h0000_0000, 1'b0, 0, "rd_lock_after_rst");
    apb_xfer(0, 1'b0, 8'h04, 32'h0, 32'h0000_0001, 1'b0, 0, "rd_status_unlocked");
`endif

    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (exp_q[i].size() != 0 || stb_q[i].size() != 0) begin
        fails++;
        $display("FAIL scoreboard_drain dut%0d: got %0d responses and %0d strobes outstanding, required 0 and 0",
                 i, exp_q[i].size(), stb_q[i].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
